// File: rtl/ste_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ste_dma_ctrl
// Brief    : Byte-to-word DMA engine between the MCU word handshake and a
//            byte-wide disk device port, with a packing FIFO and sector count.
// Revision : 1.0 - initial release
// ============================================================================
module ste_dma_ctrl #(
  parameter int FIFO_BYTES   = 16,
  parameter int SECTOR_WORDS = 256
) (
  input  logic        clk32,
  input  logic        resb,
  input  logic        clk_en,
  input  logic        FCS_N,
  input  logic        RW,
  input  logic        A1,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        RDY_I,
  output logic        RDY_O,
  input  logic        dev_drq,
  input  logic [7:0]  dev_din,
  output logic [7:0]  dev_dout,
  output logic        dev_ack
);

  localparam int c_PTR_W = $clog2(FIFO_BYTES);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_WIS_W = $clog2(SECTOR_WORDS);

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_BYTES);
  localparam logic [c_WIS_W-1:0] c_WIS_LAST = c_WIS_W'(SECTOR_WORDS - 1);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_BURST = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               r_dir;
  logic               r_err;
  logic               r_wr_held;
  logic [7:0]         r_seccnt;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_WIS_W-1:0] r_wis;
  logic [2:0]         r_burst_cnt;
  logic [7:0]         r_fifo [FIFO_BYTES];

  logic               w_idle;
  logic               w_wr_en;
  logic               w_mode_wr;
  logic               w_sec_wr;
  logic               w_flush;
  logic               w_strobe;
  logic               w_word;
  logic               w_stray;
  logic               w_dev_push;
  logic               w_dev_pop;
  logic               w_burst_last;
  logic               w_wis_wrap;
  logic [c_PTR_W-1:0] w_rd_ptr1;
  logic [c_PTR_W-1:0] w_wr_ptr1;

  assign w_idle     = (r_state == c_ST_IDLE);
  // One register write per chip-select assertion
  assign w_wr_en    = clk_en & ~FCS_N & ~RW & ~r_wr_held;
  assign w_mode_wr  = w_wr_en & A1;
  assign w_sec_wr   = w_wr_en & ~A1;
  assign w_flush    = w_mode_wr & (DIN[8] != r_dir);
  // A flush in the same enable discards any word strobe
  assign w_strobe   = clk_en & ~RDY_I & ~w_flush;
  assign w_word     = w_strobe & ~w_idle;
  assign w_stray    = w_strobe & w_idle;
  assign w_dev_push = clk_en & ~w_flush & w_idle & ~r_dir & dev_drq & (r_count != c_CNT_FULL);
  assign w_dev_pop  = clk_en & ~w_flush & w_idle & r_dir & dev_drq & (r_count != '0);
  assign w_burst_last = w_word & (r_burst_cnt == 3'd7);
  assign w_wis_wrap   = w_word & (r_wis == c_WIS_LAST);
  assign w_rd_ptr1  = r_rd_ptr + c_PTR_W'(1);
  assign w_wr_ptr1  = r_wr_ptr + c_PTR_W'(1);

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clk_en) begin
      if (w_flush) begin
        w_state_nxt = c_ST_IDLE;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if ((r_seccnt != '0) &&
                ((!r_dir && (r_count == c_CNT_FULL)) || (r_dir && (r_count == '0)))) begin
              w_state_nxt = c_ST_BURST;
            end
          end
          c_ST_BURST: begin
            if (w_burst_last) begin
              w_state_nxt = c_ST_IDLE;
            end
          end
          default: w_state_nxt = c_ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    RDY_O = (r_state != c_ST_BURST);
    if (!FCS_N && RW) begin
      DOUT = A1 ? {13'h0, dev_drq, (r_seccnt != '0), ~r_err} : {8'h00, r_seccnt};
    end else begin
      DOUT = {r_fifo[r_rd_ptr], r_fifo[w_rd_ptr1]};
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      for (int i = 0; i < FIFO_BYTES; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_word && r_dir) begin
      r_fifo[r_wr_ptr]  <= DIN[15:8];
      r_fifo[w_wr_ptr1] <= DIN[7:0];
    end else if (w_dev_push) begin
      r_fifo[r_wr_ptr]  <= dev_din;
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
      r_wr_held   <= 1'b0;
      r_seccnt    <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_wis       <= '0;
      r_burst_cnt <= '0;
      dev_ack     <= 1'b0;
      dev_dout    <= '0;
    end else if (clk_en) begin
      r_wr_held <= ~FCS_N & (r_wr_held | w_wr_en);
      dev_ack   <= w_dev_push | w_dev_pop;

      if (w_mode_wr) begin
        r_dir <= DIN[8];
      end

      if (w_sec_wr) begin
        r_seccnt <= DIN[7:0];
      end else if (w_wis_wrap && (r_seccnt != '0)) begin
        r_seccnt <= r_seccnt - 8'd1;
      end

      if (w_dev_pop) begin
        dev_dout <= r_fifo[r_rd_ptr];
      end

      if (w_flush) begin
        r_err       <= 1'b0;
        r_count     <= '0;
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_wis       <= '0;
        r_burst_cnt <= '0;
      end else begin
        if (w_stray) begin
          r_err <= 1'b1;
        end
        if (w_word) begin
          r_burst_cnt <= r_burst_cnt + 3'd1;
          r_wis       <= w_wis_wrap ? '0 : r_wis + c_WIS_W'(1);
          if (r_dir) begin
            r_count  <= r_count + c_CNT_W'(2);
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(2);
          end else begin
            r_count  <= r_count - c_CNT_W'(2);
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(2);
          end
        end else if (w_dev_push) begin
          r_count  <= r_count + c_CNT_W'(1);
          r_wr_ptr <= w_wr_ptr1;
        end else if (w_dev_pop) begin
          r_count  <= r_count - c_CNT_W'(1);
          r_rd_ptr <= w_rd_ptr1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ste_dma_ctrl.md
Name: ste_dma_ctrl

Overview:
- Byte-to-word DMA engine for the floppy/ACSI path, in the same position as the bench DMA model.
- It sits between the GSTMCU DMA handshake (FCS_N, RDY) and a byte-wide disk device port.
- A 16-byte FIFO packs device bytes into 16-bit memory words, or unpacks memory words into device bytes.
- It requests 8-word bursts from the MCU and keeps a sector count.

Parameters:
- FIFO_BYTES, 16, FIFO depth in bytes; must equal 2 x burst length.
- SECTOR_WORDS, 256, memory-side words per sector before sector count decrements.

Ports:
- clk32 in 1: system clock.
- resb in 1: asynchronous active-low reset.
- clk_en in 1: 8 MHz enable; all state advances only on clk32 edges with clk_en=1.
- FCS_N in 1: register chip select from MCU, active low.
- RW in 1: CPU read(1)/write(0).
- A1 in 1: register select; 0 = sector count, 1 = mode/status.
- DIN in 16: CPU/memory data in.
- DOUT out 16: register read data, or FIFO head word during burst.
- RDY_I in 1: active-low word strobe from MCU; one word moves per clk_en with RDY_I=0.
- RDY_O out 1: active-low burst request to MCU.
- dev_drq in 1: device ready for a byte transfer.
- dev_din in 8: device byte in.
- dev_dout out 8: device byte out.
- dev_ack out 1: one-clk_en-period pulse per device byte moved.

Behaviour:
- Reset (async, resb=0):
  - RDY_O=1, DOUT=0, dev_dout=0, dev_ack=0.
  - mode=0, seccnt=0, byte count=0, FIFO pointers=0, word-in-sector=0, err=0.
  - State=IDLE.
- Register write: first clk_en with FCS_N=0, RW=0 applies it. Further clk_en are ignored until FCS_N returns high (one write per access).
  - A1=1 writes mode: bit8 = dir (1 mem->dev, 0 dev->mem).
  - A1=0 writes seccnt = DIN[7:0].
- Flush: a mode write whose bit8 differs from the current dir performs a flush.
  - Clears byte count, pointers, word-in-sector and err.
  - Forces IDLE, even mid-burst; RDY_O=1 on that same clk_en.
  - A same-value mode write does nothing beyond storing the register.
- Register read is combinational while FCS_N=0, RW=1:
  - A1=0: {8'h00, seccnt}.
  - A1=1: {13'h0, dev_drq, seccnt!=0, ~err}.
- DOUT outside register reads = FIFO head word {byte[rd], byte[rd+1]}, high byte first.
- States:
  - IDLE:
    - dev->mem: if dev_drq=1 and count<16, push dev_din and pulse dev_ack. When count==16 and seccnt!=0, go to BURST.
    - mem->dev: if dev_drq=1 and count>0, present the head byte on dev_dout and pulse dev_ack in the same clk_en, then pop. When count==0 and seccnt!=0, go to BURST.
  - BURST:
    - RDY_O=0 from the first clk_en in BURST. Device side is frozen (no dev_ack).
    - Each clk_en with RDY_I=0 moves one word: dev->mem pops 2 bytes (DOUT valid in that cycle); mem->dev pushes DIN high byte then low byte.
    - A burst word counter counts 0..7. After the 8th strobe, RDY_O=1 on the next clk_en and state returns to IDLE.
- Sector count:
  - word-in-sector increments per strobe.
  - At SECTOR_WORDS it wraps to 0 and seccnt decrements, saturating at 0.
  - seccnt==0 blocks new bursts but never aborts a running burst.
- Error: RDY_I=0 on a clk_en in IDLE sets err and moves no data; err is sticky until flush.
- Pointers wrap modulo FIFO_BYTES. count never exceeds 16 or underflows; push at full and pop at empty are impossible by construction, and the bench asserts this.
- A register write and an RDY_I strobe in the same clk_en are both applied. A flush wins: the word is discarded.
- Reset asserted mid-burst releases RDY_O immediately (asynchronously).

Test Plan:
- Reset then idle: resb low -> RDY_O=1, DOUT=0, dev_ack=0; status read (A1=1) = 16'h0001.
- Disk read one sector:
  - Stimulus: mode=0x0000, seccnt=1, device supplies bytes 0x00..0xFF repeating with dev_drq=1.
  - Request/data: RDY_O falls after 16 acks; words read 0x0001, 0x0203 ... 0x0E0F.
  - Termination: after 32 bursts seccnt=0, RDY_O stays 1, status=0x000x with bit1=0.
- Disk write: flush to mode=0x0100, seccnt=2.
  - Burst: RDY_O falls immediately; 8 strobes with DIN=0xA55A.
  - Device side: 16 acks follow with dev_dout alternating 0xA5, 0x5A.
- Stray strobe: RDY_I=0 in IDLE -> status bit0=0, FIFO count unchanged; toggling dir clears it -> bit0=1.
- Mid-burst flush: after 3 strobes, write mode with inverted bit8 -> RDY_O=1 on the same clk_en; FIFO empty; no dev_ack issued.
- Held select: FCS_N held low across 5 clk_en with seccnt write DIN=0x0005, then DIN changes to 0x0009 -> seccnt reads 0x0005.
